// File: rtl/store_mem_access_stage.sv
// Memory-stage access unit: builds aligned store lanes and strobes and runs the
// req/addr_ok/data_ok handshake. Results are registered toward writeback.
module store_mem_access_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exe_valid,
  input  logic        exe_mem_read,
  input  logic        exe_mem_write,
  input  logic [2:0]  exe_store_type,
  input  logic [2:0]  exe_load_type,
  input  logic [31:0] exe_addr,
  input  logic [31:0] exe_store_data,
  input  logic        exe_reg_en,
  input  logic [5:0]  exe_reg_waddr,
  output logic        mem_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        wb_valid,
  output logic        wb_reg_en,
  output logic [5:0]  wb_reg_waddr,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_mem_rdata,
  output logic [2:0]  wb_load_type,
  output logic [31:0] wb_load_rt_data,
  output logic        wb_addr_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_reg, state_next;
  logic        is_store, is_load, addr_err, accept, start_mem, complete;
  logic [1:0]  a;
  logic [3:0]  sb_strb;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data;

  logic        mem_read_reg, reg_en_reg;
  logic [5:0]  reg_waddr_reg;
  logic [31:0] addr_reg, rt_reg;
  logic [2:0]  load_type_reg;

  assign a        = exe_addr[1:0];
  assign is_store = exe_mem_write;
  assign is_load  = exe_mem_read & ~exe_mem_write;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sb_lane
      assign sb_strb[gi] = (a == gi[1:0]);
    end
  endgenerate

  always_comb begin
    lane_strb = 4'b0000;
    lane_data = 32'h0;
    if (is_store) begin
      case (exe_store_type)
        3'b000: begin lane_strb = 4'b1111; lane_data = exe_store_data; end
        3'b001: begin lane_strb = sb_strb; lane_data = {4{exe_store_data[7:0]}}; end
        3'b010: begin
          lane_strb = a[1] ? 4'b1100 : 4'b0011;
          lane_data = {2{exe_store_data[15:0]}};
        end
        3'b011: begin
          // SWL fills from the addressed byte down to the low end of the word
          lane_strb = 4'b1111 >> (2'd3 - a);
          lane_data = exe_store_data >> (5'd8 * (5'd3 - {3'b000, a}));
        end
        3'b100: begin
          lane_strb = 4'b1111 << a;
          lane_data = exe_store_data << (5'd8 * {3'b000, a});
        end
        default: begin lane_strb = 4'b0000; lane_data = 32'h0; end
      endcase
    end
  end

  always_comb begin
    addr_err = 1'b0;
    if (is_store)
      addr_err = ((exe_store_type == 3'b000) && (a != 2'b00)) ||
                 ((exe_store_type == 3'b010) && a[0]);
    else if (is_load)
      addr_err = ((exe_load_type == 3'b000) && (a != 2'b00)) ||
                 (((exe_load_type == 3'b011) || (exe_load_type == 3'b100)) && a[0]);
  end

  assign accept    = (state_reg == IDLE) && exe_valid;
  assign start_mem = accept && (is_store || is_load) && !addr_err;
  assign complete  = ((state_reg == REQ) && data_addr_ok && data_data_ok) ||
                     ((state_reg == WAIT) && data_data_ok);
  assign mem_stall = (state_reg != IDLE);
  assign data_req  = (state_reg == REQ);

  always_ff @(posedge clk) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_mem) state_next = REQ;
      REQ:     if (data_addr_ok) state_next = data_data_ok ? IDLE : WAIT;
      WAIT:    if (data_data_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_read_reg    <= 1'b0;
      reg_en_reg      <= 1'b0;
      reg_waddr_reg   <= 6'd0;
      addr_reg        <= 32'h0;
      rt_reg          <= 32'h0;
      load_type_reg   <= 3'd0;
      data_wr         <= 1'b0;
      data_addr       <= 32'h0;
      data_wstrb      <= 4'b0000;
      data_wdata      <= 32'h0;
      wb_valid        <= 1'b0;
      wb_reg_en       <= 1'b0;
      wb_reg_waddr    <= 6'd0;
      wb_alu_result   <= 32'h0;
      wb_mem_rdata    <= 32'h0;
      wb_load_type    <= 3'd0;
      wb_load_rt_data <= 32'h0;
      wb_addr_err     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept) begin
        mem_read_reg  <= is_load;
        reg_en_reg    <= exe_reg_en;
        reg_waddr_reg <= exe_reg_waddr;
        addr_reg      <= exe_addr;
        rt_reg        <= exe_store_data;
        load_type_reg <= exe_load_type;
        data_wr       <= is_store;
        data_addr     <= {exe_addr[31:2], 2'b00};
        data_wstrb    <= lane_strb;
        data_wdata    <= lane_data;
        // Non-memory ops and rejected accesses retire straight from IDLE
        if (!start_mem) begin
          wb_valid        <= 1'b1;
          wb_reg_en       <= exe_reg_en & ~addr_err;
          wb_reg_waddr    <= exe_reg_waddr;
          wb_alu_result   <= exe_addr;
          wb_mem_rdata    <= 32'h0;
          wb_load_type    <= exe_load_type;
          wb_load_rt_data <= exe_store_data;
          wb_addr_err     <= addr_err;
        end
      end else if (complete) begin
        wb_valid        <= 1'b1;
        wb_reg_en       <= reg_en_reg;
        wb_reg_waddr    <= reg_waddr_reg;
        wb_alu_result   <= addr_reg;
        wb_mem_rdata    <= mem_read_reg ? data_rdata : 32'h0;
        wb_load_type    <= load_type_reg;
        wb_load_rt_data <= rt_reg;
        wb_addr_err     <= 1'b0;
      end
    end
  end

endmodule
